// File: rtl/set_input_ctrl_pkg.sv
// Shared encodings and field-sequencing helpers for the set-button front end.
package set_input_ctrl_pkg;

  localparam logic [1:0] CLOCK_MODE = 2'b00;
  localparam logic [1:0] SET_MODE   = 2'b01;
  localparam logic [1:0] ALARM_MODE = 2'b10;

  typedef enum logic [2:0] {
    NONESET = 3'b000,
    SECSET  = 3'b001,
    MINSET  = 3'b010,
    HOURSET = 3'b100
  } field_e;

  // Mode 2'b11 is deliberately not a setting mode; it behaves as clock mode.
  function automatic logic is_setting_mode(input logic [1:0] m);
    return (m == SET_MODE) || (m == ALARM_MODE);
  endfunction

  // Alarm has no seconds field, so anything other than MIN advances to MIN.
  function automatic field_e next_field(input logic [1:0] m, input field_e f);
    if (m == SET_MODE) begin
      case (f)
        NONESET: return SECSET;
        SECSET:  return MINSET;
        MINSET:  return HOURSET;
        default: return SECSET;
      endcase
    end
    return (f == MINSET) ? HOURSET : MINSET;
  endfunction

endpackage

// File: rtl/set_input_ctrl_btn_debounce.sv
// One pushbutton: 2-flop synchroniser, stable-count debounce and a registered
// pulse on each accepted press (not on release).
module set_input_ctrl_btn_debounce #(
  parameter int DEB_CYC        = 1000000,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int              CW      = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0]   DEB_MAX = CW'(DEB_CYC);

  logic [1:0]    sync;
  logic          pressed;
  logic [CW-1:0] cnt;

  assign pressed = sync[1] ^ BTN_ACTIVE_LOW;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the real hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= {2{BTN_ACTIVE_LOW}};
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], btn_raw};
      if (pressed == level) begin
        cnt  <= '0;
        rise <= 1'b0;
      end else if (cnt == DEB_MAX) begin
        level <= pressed;
        cnt   <= '0;
        rise  <= pressed;
      end else begin
        cnt  <= cnt + 1'b1;
        rise <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/set_input_ctrl.sv
// Set-button front end: debounced buttons, field-select FSM and gated
// increment command with hold-to-repeat.
module set_input_ctrl
  import set_input_ctrl_pkg::*;
#(
  parameter int DEB_CYC        = 1000000,
  parameter int HOLD_CYC       = 25000000,
  parameter int REP_CYC        = 5000000,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic       original_clk,
  input  logic       clr_n,
  input  logic [1:0] mode,
  input  logic       posswitch,
  input  logic       changetime,
  output logic [2:0] field,
  output logic       sel_pulse,
  output logic       inc_pulse,
  output logic       chg_held
);

  localparam int            HOLD_MAX  = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int            HW        = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REP_CYC - 1);

  logic          sel_rise, chg_rise, chg_level;
  field_e        field_q, field_d;
  logic [1:0]    mode_q;
  logic          gate_open, rep_fire, inc_fire;
  logic          armed, repeating;
  logic [HW-1:0] hold_cnt;

  set_input_ctrl_btn_debounce #(.DEB_CYC(DEB_CYC), .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)) u_pos_deb (
    .clk(original_clk), .rst_n(clr_n), .btn_raw(posswitch), .level(), .rise(sel_rise)
  );

  set_input_ctrl_btn_debounce #(.DEB_CYC(DEB_CYC), .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)) u_chg_deb (
    .clk(original_clk), .rst_n(clr_n), .btn_raw(changetime), .level(chg_level), .rise(chg_rise)
  );

  assign field    = field_q;
  assign chg_held = chg_level;

  // NOTE: the default assignment first guarantees every path drives field_d,
  // so no latch is inferred.
  always_comb begin
    field_d = field_q;
    if ((mode != mode_q) || !is_setting_mode(mode)) field_d = NONESET;
    else if (sel_pulse)                             field_d = next_field(mode, field_q);
  end

  always_ff @(posedge original_clk or negedge clr_n) begin
    if (!clr_n) begin
      field_q <= NONESET;
      mode_q  <= CLOCK_MODE;
    end else begin
      field_q <= field_d;
      mode_q  <= mode;
    end
  end

  // Repeat timer counts from the last emitted inc pulse; the first gap is
  // HOLD_CYC, later gaps REP_CYC.
  assign gate_open = (field_q != NONESET) && is_setting_mode(mode);
  assign rep_fire  = armed && (hold_cnt == (repeating ? REP_LAST : HOLD_LAST));
  assign inc_fire  = gate_open && chg_level && (chg_rise || rep_fire);

  always_ff @(posedge original_clk or negedge clr_n) begin
    if (!clr_n) begin
      sel_pulse <= 1'b0;
      inc_pulse <= 1'b0;
      armed     <= 1'b0;
      repeating <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      sel_pulse <= sel_rise;
      inc_pulse <= inc_fire;
      if (!(chg_level && gate_open)) begin
        armed     <= 1'b0;
        repeating <= 1'b0;
        hold_cnt  <= '0;
      end else if (inc_fire) begin
        armed     <= 1'b1;
        repeating <= !chg_rise;
        hold_cnt  <= '0;
      end else if (armed) begin
        hold_cnt  <= hold_cnt + 1'b1;
      end
    end
  end

endmodule
